// File: rtl/powlib_serializer.sv
// Wide-to-narrow serializer: accepts one W-bit word and emits it as N beats of
// W/N bits, least-significant beat first, with no idle cycle between words.
module powlib_serializer #(
  parameter int W    = 16,
  parameter int N    = 4,
  parameter int EDBG = 0,
  parameter     ID   = "SERIALIZER"
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [W-1:0]    wrdata,
  input  logic            wrvld,
  output logic            wrrdy,
  output logic [W/N-1:0]  rddata,
  output logic            rdvld,
  input  logic            rdrdy,
  output logic            rdlast
);

  localparam int WO = W / N;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(N - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    BUSY  = 1'b1
  } state_t;

  state_t          state_reg;
  logic [CW-1:0]   cntr_reg;
  logic [W-1:0]    word_reg;
  logic            rdinc;
  logic            wrinc;

  // A misconfigured width split would silently drop upper bits, so stop early.
  generate
    if (EDBG != 0 && (W % N) != 0) begin : g_param_check
      $fatal(1, "%s: W=%0d is not a multiple of N=%0d", ID, W, N);
    end
  endgenerate

  assign rdvld  = (state_reg == BUSY);
  assign rdlast = rdvld && (cntr_reg == LAST_BEAT);
  assign rdinc  = rdvld && rdrdy;
  assign wrrdy  = !rdvld || (rdinc && rdlast);
  assign wrinc  = wrvld && wrrdy;

  generate
    if (N == 1) begin : g_single
      assign rddata = word_reg[WO-1:0];
    end else begin : g_multi
      logic [WO-1:0] beats [N];
      for (genvar gi = 0; gi < N; gi++) begin : g_beat
        assign beats[gi] = word_reg[gi*WO +: WO];
      end
      assign rddata = beats[cntr_reg];
    end
  endgenerate

  // Loading a new word wins over advancing: it only happens when empty or
  // when the final beat is leaving this same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= EMPTY;
      cntr_reg  <= '0;
      word_reg  <= '0;
    end else if (wrinc) begin
      word_reg  <= wrdata;
      cntr_reg  <= '0;
      state_reg <= BUSY;
    end else if (rdinc) begin
      if (rdlast) begin
        cntr_reg  <= '0;
        state_reg <= EMPTY;
      end else begin
        cntr_reg  <= cntr_reg + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_powlib_serializer.sv
// Scoreboard bench for powlib_serializer: a W=16/N=4 instance and a W=8/N=1
// instance, expected beats queued on word acceptance and compared on output.
module tb_powlib_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] wrdata4;
  logic        wrvld4, wrrdy4, rdvld4, rdrdy4, rdlast4;
  logic [3:0]  rddata4;
  logic [7:0]  wrdata1, rddata1;
  logic        wrvld1, wrrdy1, rdvld1, rdrdy1, rdlast1;

  int errors = 0;
  int checks = 0;

  logic [4:0] sb4[$];
  logic [8:0] sb1[$];
  logic       exp_vld, exp_wr;

  typedef struct packed {
    logic        rs;
    logic        wv;
    logic [15:0] wd;
    logic        rr;
  } stim_t;

  always #5 clk = ~clk;

  powlib_serializer #(.W(16), .N(4)) dut4 (
    .clk(clk), .rst(rst),
    .wrdata(wrdata4), .wrvld(wrvld4), .wrrdy(wrrdy4),
    .rddata(rddata4), .rdvld(rdvld4), .rdrdy(rdrdy4), .rdlast(rdlast4)
  );

  powlib_serializer #(.W(8), .N(1)) dut1 (
    .clk(clk), .rst(rst),
    .wrdata(wrdata1), .wrvld(wrvld1), .wrrdy(wrrdy1),
    .rddata(rddata1), .rdvld(rdvld1), .rdrdy(rdrdy1), .rdlast(rdlast1)
  );

  task automatic drive4(input stim_t s);
    @(negedge clk);
    rst     = s.rs;
    wrvld4  = s.wv;
    wrdata4 = s.wd;
    rdrdy4  = s.rr;
    #1;
  endtask

  // Model of the accepting edge: reset flushes, an accepted word queues N beats.
  task automatic commit4();
    if (rst) begin
      sb4.delete();
    end else if (wrvld4 && exp_wr) begin
      for (int b = 0; b < 4; b++) sb4.push_back({b == 3, wrdata4[b*4 +: 4]});
      $display("word4 accepted %h", wrdata4);
    end
  endtask

  task automatic test_reset();
    stim_t s;
    s = '{rs: 1'b1, wv: 1'b0, wd: 16'h0, rr: 1'b1};
    wrvld1 = 1'b0; wrdata1 = 8'h0; rdrdy1 = 1'b1;
    drive4(s);
    s = '{rs: 1'b1, wv: 1'b1, wd: 16'h5555, rr: 1'b1};
    drive4(s);
    s = '{rs: 1'b0, wv: 1'b0, wd: 16'h0, rr: 1'b1};
    drive4(s);
    sb4.delete();
    sb1.delete();
    checks++; if (rdvld4 !== 1'b0) begin errors++; $display("FAIL reset rdvld4 got=%b exp=0", rdvld4); end
    checks++; if (rdlast4 !== 1'b0) begin errors++; $display("FAIL reset rdlast4 got=%b exp=0", rdlast4); end
    checks++; if (wrrdy4 !== 1'b1) begin errors++; $display("FAIL reset wrrdy4 got=%b exp=1", wrrdy4); end
    checks++; if (rddata4 !== 4'h0) begin errors++; $display("FAIL reset rddata4 got=%h exp=0", rddata4); end
    checks++; if (rdvld1 !== 1'b0) begin errors++; $display("FAIL reset rdvld1 got=%b exp=0", rdvld1); end
    checks++; if (wrrdy1 !== 1'b1) begin errors++; $display("FAIL reset wrrdy1 got=%b exp=1", wrrdy1); end
    checks++; if (rddata1 !== 8'h0) begin errors++; $display("FAIL reset rddata1 got=%h exp=0", rddata1); end
    $display("reset done");
  endtask

  task automatic test_single();
    stim_t st[$];
    logic [4:0] e;
    st.push_back('{rs: 1'b0, wv: 1'b1, wd: 16'hABCD, rr: 1'b1});
    for (int k = 0; k < 5; k++) st.push_back('{rs: 1'b0, wv: 1'b0, wd: 16'h0, rr: 1'b1});
    foreach (st[i]) begin
      drive4(st[i]);
      exp_vld = (sb4.size() != 0);
      exp_wr  = !exp_vld || (rdrdy4 && sb4[0][4]);
      checks++; if (rdvld4 !== exp_vld) begin errors++; $display("FAIL single c%0d rdvld got=%b exp=%b", i, rdvld4, exp_vld); end
      checks++; if (wrrdy4 !== exp_wr) begin errors++; $display("FAIL single c%0d wrrdy got=%b exp=%b", i, wrrdy4, exp_wr); end
      if (exp_vld) begin
        e = sb4[0];
        checks++; if ({rdlast4, rddata4} !== e) begin errors++; $display("FAIL single c%0d beat got=%b/%h exp=%b/%h", i, rdlast4, rddata4, e[4], e[3:0]); end
        if (rdrdy4) begin void'(sb4.pop_front()); $display("single beat %h last=%b", rddata4, rdlast4); end
      end else begin
        checks++; if (rdlast4 !== 1'b0) begin errors++; $display("FAIL single c%0d rdlast idle got=%b exp=0", i, rdlast4); end
      end
      commit4();
    end
  endtask

  task automatic test_back_to_back();
    stim_t st[$];
    logic [4:0] e;
    st.push_back('{rs: 1'b0, wv: 1'b1, wd: 16'h1234, rr: 1'b1});
    for (int k = 0; k < 4; k++) st.push_back('{rs: 1'b0, wv: 1'b1, wd: 16'h5678, rr: 1'b1});
    for (int k = 0; k < 5; k++) st.push_back('{rs: 1'b0, wv: 1'b0, wd: 16'h0, rr: 1'b1});
    foreach (st[i]) begin
      drive4(st[i]);
      exp_vld = (sb4.size() != 0);
      exp_wr  = !exp_vld || (rdrdy4 && sb4[0][4]);
      checks++; if (rdvld4 !== exp_vld) begin errors++; $display("FAIL b2b c%0d rdvld got=%b exp=%b", i, rdvld4, exp_vld); end
      checks++; if (wrrdy4 !== exp_wr) begin errors++; $display("FAIL b2b c%0d wrrdy got=%b exp=%b", i, wrrdy4, exp_wr); end
      if (exp_vld) begin
        e = sb4[0];
        checks++; if ({rdlast4, rddata4} !== e) begin errors++; $display("FAIL b2b c%0d beat got=%b/%h exp=%b/%h", i, rdlast4, rddata4, e[4], e[3:0]); end
        if (rdrdy4) begin void'(sb4.pop_front()); $display("b2b beat %h last=%b", rddata4, rdlast4); end
      end
      commit4();
    end
  endtask

  task automatic test_backpressure();
    stim_t st[$];
    logic [4:0] e;
    st.push_back('{rs: 1'b0, wv: 1'b1, wd: 16'hABCD, rr: 1'b1});
    st.push_back('{rs: 1'b0, wv: 1'b0, wd: 16'h0, rr: 1'b1});
    // Offer a competing word while stalled: it must not be taken.
    for (int k = 0; k < 3; k++) st.push_back('{rs: 1'b0, wv: 1'b1, wd: 16'h9999, rr: 1'b0});
    for (int k = 0; k < 4; k++) st.push_back('{rs: 1'b0, wv: 1'b0, wd: 16'h0, rr: 1'b1});
    foreach (st[i]) begin
      drive4(st[i]);
      exp_vld = (sb4.size() != 0);
      exp_wr  = !exp_vld || (rdrdy4 && sb4[0][4]);
      checks++; if (rdvld4 !== exp_vld) begin errors++; $display("FAIL bp c%0d rdvld got=%b exp=%b", i, rdvld4, exp_vld); end
      checks++; if (wrrdy4 !== exp_wr) begin errors++; $display("FAIL bp c%0d wrrdy got=%b exp=%b", i, wrrdy4, exp_wr); end
      if (exp_vld) begin
        e = sb4[0];
        checks++; if ({rdlast4, rddata4} !== e) begin errors++; $display("FAIL bp c%0d beat got=%b/%h exp=%b/%h", i, rdlast4, rddata4, e[4], e[3:0]); end
        if (rdrdy4) begin void'(sb4.pop_front()); $display("bp beat %h last=%b", rddata4, rdlast4); end
      end
      commit4();
    end
    checks++; if (sb4.size() != 0) begin errors++; $display("FAIL bp leftover beats got=%0d exp=0", sb4.size()); end
  endtask

  task automatic test_reset_midword();
    stim_t st[$];
    logic [4:0] e;
    st.push_back('{rs: 1'b0, wv: 1'b1, wd: 16'hABCD, rr: 1'b1});
    st.push_back('{rs: 1'b0, wv: 1'b0, wd: 16'h0, rr: 1'b1});
    st.push_back('{rs: 1'b0, wv: 1'b0, wd: 16'h0, rr: 1'b1});
    st.push_back('{rs: 1'b1, wv: 1'b0, wd: 16'h0, rr: 1'b1});
    st.push_back('{rs: 1'b0, wv: 1'b1, wd: 16'h00F1, rr: 1'b1});
    for (int k = 0; k < 5; k++) st.push_back('{rs: 1'b0, wv: 1'b0, wd: 16'h0, rr: 1'b1});
    foreach (st[i]) begin
      drive4(st[i]);
      exp_vld = (sb4.size() != 0);
      exp_wr  = !exp_vld || (rdrdy4 && sb4[0][4]);
      checks++; if (rdvld4 !== exp_vld) begin errors++; $display("FAIL rstmid c%0d rdvld got=%b exp=%b", i, rdvld4, exp_vld); end
      checks++; if (wrrdy4 !== exp_wr) begin errors++; $display("FAIL rstmid c%0d wrrdy got=%b exp=%b", i, wrrdy4, exp_wr); end
      if (i == 4) begin
        checks++; if (rddata4 !== 4'h0) begin errors++; $display("FAIL rstmid rddata after reset got=%h exp=0", rddata4); end
      end
      if (exp_vld) begin
        e = sb4[0];
        checks++; if ({rdlast4, rddata4} !== e) begin errors++; $display("FAIL rstmid c%0d beat got=%b/%h exp=%b/%h", i, rdlast4, rddata4, e[4], e[3:0]); end
        if (rdrdy4) begin void'(sb4.pop_front()); $display("rstmid beat %h last=%b", rddata4, rdlast4); end
      end
      commit4();
    end
  endtask

  task automatic test_n1();
    logic [7:0] wd [7] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h44, 8'h00, 8'h00};
    logic       wv [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       rr [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [8:0] e;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      wrvld1  = wv[i];
      wrdata1 = wd[i];
      rdrdy1  = rr[i];
      #1;
      exp_vld = (sb1.size() != 0);
      exp_wr  = !exp_vld || rdrdy1;
      checks++; if (rdvld1 !== exp_vld) begin errors++; $display("FAIL n1 c%0d rdvld got=%b exp=%b", i, rdvld1, exp_vld); end
      checks++; if (wrrdy1 !== exp_wr) begin errors++; $display("FAIL n1 c%0d wrrdy got=%b exp=%b", i, wrrdy1, exp_wr); end
      if (exp_vld) begin
        e = sb1[0];
        checks++; if ({rdlast1, rddata1} !== e) begin errors++; $display("FAIL n1 c%0d beat got=%b/%h exp=%b/%h", i, rdlast1, rddata1, e[8], e[7:0]); end
        if (rdrdy1) begin void'(sb1.pop_front()); $display("n1 beat %h last=%b", rddata1, rdlast1); end
      end
      if (wrvld1 && exp_wr) sb1.push_back({1'b1, wrdata1});
    end
    checks++; if (sb1.size() != 0) begin errors++; $display("FAIL n1 leftover beats got=%0d exp=0", sb1.size()); end
  endtask

  initial begin
    rst = 1'b1; wrvld4 = 1'b0; wrdata4 = '0; rdrdy4 = 1'b1;
    wrvld1 = 1'b0; wrdata1 = '0; rdrdy1 = 1'b1;
    exp_vld = 1'b0; exp_wr = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_midword();
    test_n1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
